// File: rtl/full_adder_checker.sv
// Response checker for a 1-bit full adder: counts vectors/mismatches, records the first failure, tracks coverage.
// Latency: 1 cycle from a sampled vector to updated counters; the verdict is registered with the last vector.
// Backpressure: none; every in_valid cycle in RUN is accepted, and in_valid is ignored in IDLE and DONE.
module full_adder_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec,
  output logic [7:0]       coverage
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The run ends on the vector that brings vec_count to NUM_VECTORS.
  localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(NUM_VECTORS - 1);
  // With fewer than 8 vectors full coverage is impossible, so it is not demanded.
  localparam bit               LP_CHK_COV = (NUM_VECTORS >= 8);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_arm;
  logic             w_accept;
  logic             w_last;
  logic             w_mismatch;
  logic             w_cov_ok;
  logic             w_pass_nxt;
  logic [1:0]       w_expected;
  logic [2:0]       w_vec;
  logic [CNT_W-1:0] w_err_nxt;
  logic [7:0]       w_cov_nxt;

  // Reference arithmetic, vector acceptance and next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    w_vec       = {a, b, cin};
    w_expected  = {1'b0, a} + {1'b0, b} + {1'b0, cin};
    w_mismatch  = ({cout, sum} != w_expected);
    w_arm       = start && (r_state != S_RUN);
    w_accept    = in_valid && (r_state == S_RUN);
    w_last      = w_accept && (vec_count == LP_LAST);
    w_err_nxt   = (w_mismatch && (err_count != {CNT_W{1'b1}}))
                  ? err_count + CNT_W'(1) : err_count;
    w_cov_nxt   = coverage | (8'b1 << w_vec);
    w_cov_ok    = !LP_CHK_COV || (w_cov_nxt == 8'hFF);
    w_pass_nxt  = (w_err_nxt == '0) && w_cov_ok;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (start)  w_state_nxt = S_RUN;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered status flags, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_state_nxt == S_RUN);
      done <= (w_state_nxt == S_DONE);
    end
  end

  // Run statistics: cleared on arming, updated on each accepted vector, verdict on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass            <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
      coverage        <= 8'h00;
    end else if (w_arm) begin
      pass            <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'b000;
      coverage        <= 8'h00;
    end else if (w_accept) begin
      vec_count <= vec_count + CNT_W'(1);
      err_count <= w_err_nxt;
      coverage  <= w_cov_nxt;
      if (w_mismatch && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_vec   <= w_vec;
      end
      if (w_last) pass <= w_pass_nxt;
    end
  end

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker: a spec-level model predicts every output after every cycle.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied one vector per cycle with optional gaps.
module tb_full_adder_checker;

  localparam int NV  = 8;
  localparam int SNV = 255;

  logic       clk;
  logic       rst_n;
  logic       start, in_valid, a, b, cin, sum, cout;
  logic       busy, done, pass, first_err_valid;
  logic [7:0] vec_count, err_count, coverage;
  logic [2:0] first_err_vec;

  logic       s_start, s_valid, s_a, s_b, s_cin, s_sum, s_cout;
  logic       s_busy, s_done, s_pass, s_fev;
  logic [7:0] s_vec_count, s_err_count, s_coverage;
  logic [2:0] s_fe;

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    step   = 0;
  string cur_test = "";

  // Model of the checker, kept as plain run statistics.
  int         m_state = 0;  // 0 idle, 1 run, 2 done
  int         m_vec   = 0;
  int         m_err   = 0;
  logic       m_fv    = 1'b0;
  logic [2:0] m_fe    = 3'b000;
  logic [7:0] m_cov   = 8'h00;
  logic       m_pass  = 1'b0;

  full_adder_checker #(.NUM_VECTORS(NV), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .coverage(coverage)
  );

  full_adder_checker #(.NUM_VECTORS(SNV), .CNT_W(8)) sdut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
    .a(s_a), .b(s_b), .cin(s_cin), .sum(s_sum), .cout(s_cout),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_count(s_vec_count), .err_count(s_err_count),
    .first_err_valid(s_fev), .first_err_vec(s_fe),
    .coverage(s_coverage)
  );

  wire [30:0] w_obs  = {busy, done, pass, vec_count, err_count, first_err_valid, first_err_vec, coverage};
  wire [30:0] w_sobs = {s_busy, s_done, s_pass, s_vec_count, s_err_count, s_fev, s_fe, s_coverage};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [30:0] pack(input logic bz, input logic dn, input logic ps,
                                       input logic [7:0] vc, input logic [7:0] ec,
                                       input logic fv, input logic [2:0] fe, input logic [7:0] cv);
    return {bz, dn, ps, vc, ec, fv, fe, cv};
  endfunction

  function automatic logic [30:0] model_exp();
    return pack(m_state == 1, m_state == 2, m_pass, 8'(m_vec), 8'(m_err), m_fv, m_fe, m_cov);
  endfunction

  task automatic model_reset();
    m_state = 0; m_vec = 0; m_err = 0; m_fv = 1'b0; m_fe = 3'b000; m_cov = 8'h00; m_pass = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model by the documented rules, compare everything.
  task automatic apply(input logic st, input logic v, input logic ia, input logic ib,
                       input logic ic, input logic is, input logic ico);
    int total, seen;
    start = st; in_valid = v; a = ia; b = ib; cin = ic; sum = is; cout = ico;
    @(posedge clk);
    if (m_state != 1 && st) begin
      model_reset();
      m_state = 1;
    end else if (m_state == 1 && v) begin
      total = int'(ia) + int'(ib) + int'(ic);
      seen  = int'(is) + 2 * int'(ico);
      m_vec = m_vec + 1;
      m_cov[{ia, ib, ic}] = 1'b1;
      if (seen != total) begin
        if (m_err < 255) m_err = m_err + 1;
        if (!m_fv) begin
          m_fv = 1'b1;
          m_fe = {ia, ib, ic};
        end
      end
      if (m_vec == NV) begin
        m_state = 2;
        m_pass  = (m_err == 0) && (m_cov == 8'hFF);
      end
    end
    #1;
    step++;
    n_cmp++;
    if (w_obs !== model_exp()) begin
      n_fail++;
      $display("FAIL %s step %0d: outputs got %h want %h", cur_test, step, w_obs, model_exp());
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Correct adder response for combination k, with optional forced bits.
  task automatic apply_vec(input logic st, input int k, input logic kill_sum, input logic kill_cout);
    logic [2:0] kv;
    logic [1:0] r;
    kv = 3'(k);
    r  = 2'(int'(kv[2]) + int'(kv[1]) + int'(kv[0]));
    apply(st, 1'b1, kv[2], kv[1], kv[0], r[0] & ~kill_sum, r[1] & ~kill_cout);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst_n = 1'b1;
    start = 0; in_valid = 0; a = 0; b = 0; cin = 0; sum = 0; cout = 0;
    s_start = 0; s_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sum = 0; s_cout = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (w_obs !== 31'h0) begin
      n_fail++;
      $display("FAIL reset_main: outputs got %h want %h", w_obs, 31'h0);
    end
    n_cmp++;
    if (w_sobs !== 31'h0) begin
      n_fail++;
      $display("FAIL reset_sat: outputs got %h want %h", w_sobs, 31'h0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_ignore();
    cur_test = "idle_ignore";
    for (int k = 0; k < 3; k++) apply_vec(1'b0, k, 1'b0, 1'b0);
    n_cmp++;
    if (vec_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: vec_count/busy got %0d/%b want 0/0", vec_count, busy);
    end
  endtask

  task automatic test_exhaustive();
    cur_test = "exhaustive";
    apply(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) apply_vec(1'b0, k, 1'b0, 1'b0);
    n_cmp++;
    if (w_obs !== pack(0, 1, 1, 8'd8, 8'd0, 0, 3'b000, 8'hFF)) begin
      n_fail++;
      $display("FAIL exhaustive_final: got %h want %h", w_obs, pack(0, 1, 1, 8'd8, 8'd0, 0, 3'b000, 8'hFF));
    end
  endtask

  task automatic test_faults();
    cur_test = "faults";
    apply(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) apply_vec(1'b0, k, k == 7, k == 3);
    n_cmp++;
    if (w_obs !== pack(0, 1, 0, 8'd8, 8'd2, 1, 3'b011, 8'hFF)) begin
      n_fail++;
      $display("FAIL faults_final: got %h want %h", w_obs, pack(0, 1, 0, 8'd8, 8'd2, 1, 3'b011, 8'hFF));
    end
  endtask

  task automatic test_coverage_hole();
    cur_test = "coverage_hole";
    apply(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) apply_vec(1'b0, (k == 6) ? 5 : k, 1'b0, 1'b0);
    n_cmp++;
    if (w_obs !== pack(0, 1, 0, 8'd8, 8'd0, 0, 3'b000, 8'hBF)) begin
      n_fail++;
      $display("FAIL coverage_hole_final: got %h want %h", w_obs, pack(0, 1, 0, 8'd8, 8'd0, 0, 3'b000, 8'hBF));
    end
  endtask

  task automatic test_gaps();
    cur_test = "gaps";
    apply(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) apply_vec(1'b0, k, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) apply(1'b0, 1'b0, 1, 1, 1, 0, 0);
    n_cmp++;
    if (vec_count !== 8'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_hold: vec_count/busy got %0d/%b want 3/1", vec_count, busy);
    end
    apply_vec(1'b1, 3, 1'b0, 1'b0);
    n_cmp++;
    if (vec_count !== 8'd4 || coverage !== 8'h0F) begin
      n_fail++;
      $display("FAIL start_in_run: vec_count/coverage got %0d/%h want 4/0f", vec_count, coverage);
    end
    for (int k = 4; k < 8; k++) apply_vec(1'b0, k, 1'b0, 1'b0);
    n_cmp++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_final: done/pass got %b/%b want 1/1", done, pass);
    end
    // In DONE, further vectors are ignored.
    apply_vec(1'b0, 2, 1'b1, 1'b1);
  endtask

  task automatic test_rearm_reset();
    cur_test = "rearm_reset";
    apply_vec(1'b1, 6, 1'b1, 1'b0);
    n_cmp++;
    if (w_obs !== pack(1, 0, 0, 8'd0, 8'd0, 0, 3'b000, 8'h00)) begin
      n_fail++;
      $display("FAIL rearm: got %h want %h", w_obs, pack(1, 0, 0, 8'd0, 8'd0, 0, 3'b000, 8'h00));
    end
    apply_vec(1'b0, 1, 1'b1, 1'b0);
    apply_vec(1'b0, 2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (w_obs !== 31'h0) begin
      n_fail++;
      $display("FAIL async_reset: outputs got %h want %h", w_obs, 31'h0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int budget;
    cur_test = "random";
    for (int run = 0; run < 4; run++) begin
      apply(1'b1, 1'b0, 0, 0, 0, 0, 0);
      budget = 200;
      while (m_state == 1 && budget > 0) begin
        apply($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
              1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
        budget--;
      end
      n_cmp++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL random_done run %0d: done got %b want 1", run, done);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] r;
    cur_test = "saturation";
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int i = 1; i <= SNV; i++) begin
      s_valid = 1'b1;
      {s_a, s_b, s_cin} = 3'($urandom);
      r = 2'(int'(s_a) + int'(s_b) + int'(s_cin));
      {s_cout, s_sum} = ~r;
      @(posedge clk);
      #1;
      if (i == 100) begin
        n_cmp++;
        if (s_err_count !== 8'd100 || s_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_mid: err_count/busy got %0d/%b want 100/1", s_err_count, s_busy);
        end
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (s_err_count !== 8'd255 || s_vec_count !== 8'd255 || s_done !== 1'b1
        || s_busy !== 1'b0 || s_pass !== 1'b0 || s_fev !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_final: err/vec/done/busy/pass got %0d/%0d/%b/%b/%b want 255/255/1/0/0",
               s_err_count, s_vec_count, s_done, s_busy, s_pass);
    end
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    n_cmp++;
    if (s_err_count !== 8'd255 || s_vec_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hold: err/vec got %0d/%0d want 255/255", s_err_count, s_vec_count);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_exhaustive();
    test_faults();
    test_coverage_hole();
    test_gaps();
    test_rearm_reset();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_checker.md
# full_adder_checker

Clocked response checker for the 1-bit full adder: the receive end of the adder's stimulus/response loop. Each valid cycle it samples the applied inputs `a`, `b`, `cin` and the observed adder outputs `sum`, `cout`. It compares the observed outputs against the arithmetic reference, counts vectors and mismatches, records the first failing vector, and tracks coverage of all 8 input combinations. It sits beside the adder in bench and self-test builds and produces a registered pass/fail verdict at the end of each run.

## Interface
- `NUM_VECTORS`, default 8: vectors per run; range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the vector and error counters.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that arms a new run.
- `in_valid`  in  1  the current a/b/cin/sum/cout form one vector.
- `a`, `b`, `cin`  in  1 each  inputs applied to the adder.
- `sum`, `cout`  in  1 each  outputs observed from the adder.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  verdict; meaningful only while `done`=1.
- `vec_count`  out  CNT_W  vectors accepted in this run.
- `err_count`  out  CNT_W  mismatches in this run; saturates at all-ones.
- `first_err_valid`  out  1  a mismatch has been captured this run.
- `first_err_vec`  out  3  {a,b,cin} of the first mismatch.
- `coverage`  out  8  bit k set once input combination {a,b,cin}=k has been seen.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset enters IDLE. The state and all outputs are registered.
- IDLE: `start` moves the FSM to RUN and clears `vec_count`, `err_count`, `first_err_*` and `coverage`. `in_valid` is ignored.
- RUN, on each `in_valid`:
  - expected = a + b + cin as a 2-bit value {exp_cout, exp_sum}.
  - mismatch = ({cout,sum} != expected).
  - `vec_count` increments.
  - `coverage[{a,b,cin}]` is set.
  - On a mismatch, `err_count` increments, saturating.
  - On a mismatch while `first_err_valid`=0, `first_err_vec` is loaded and `first_err_valid` is set. Later mismatches do not overwrite it.
- RUN to DONE: taken on the edge where an accepted vector brings `vec_count` to NUM_VECTORS.
- `start` in RUN is ignored. A run cannot be aborted except by reset.
- DONE: counters hold and `in_valid` is ignored.
  - `pass` = (err_count==0) && (coverage==8'hFF when NUM_VECTORS>=8; otherwise coverage check skipped).
  - `start` in DONE re-arms the block: it clears the run state exactly as from IDLE and enters RUN.
- `vec_count` cannot wrap, because NUM_VECTORS < 2^CNT_W. `err_count` saturates at 2^CNT_W-1.

## Timing
- Reset (async assert, sync-to-clk deassert by the system) drives:
  - state to IDLE;
  - `busy`, `done`, `pass` to 0;
  - `vec_count`, `err_count` to 0;
  - `first_err_valid` to 0, `first_err_vec` to 3'b000;
  - `coverage` to 8'h00.
- Reset asserted mid-run aborts immediately to these values.
- `start` sampled at edge N: `busy`=1 and counters are 0 after edge N. A vector presented with `in_valid` at edge N is not counted; the first countable vector is at edge N+1.
- Vector sampled at edge N: its effect on the counters, `coverage` and `first_err_*` is visible after edge N, so latency is 1 cycle.
- Last vector at edge N: after edge N, `done`=1, `busy`=0 and `pass` is valid, all in the same cycle. `vec_count` equals NUM_VECTORS.
- `in_valid` and `start` both high in DONE: `start` wins; the vector is not counted.
- `done` stays high until `start` or reset.
- The adder is combinational, so the bench presents a/b/cin and the resulting sum/cout in the same valid cycle.

## Test plan
- Exhaustive pass: reset, pulse `start`, then 8 vectors {a,b,cin}=0..7 with correct sum/cout, one per cycle. Required after the last edge: `done`=1, `pass`=1, `vec_count`=8, `err_count`=0, `coverage`=8'hFF, `first_err_valid`=0.
- Injected faults: as the exhaustive run, but force `cout`=0 at vector 3 and `sum`=0 at vector 7. Required: `err_count`=2, `first_err_vec`=3'b011, `first_err_valid`=1, `pass`=0.
- Coverage hole: 8 correct vectors with combination 5 repeated in place of 6. Required: `coverage`=8'hBF, `err_count`=0, `pass`=0.
- Gaps and ignored inputs: drop `in_valid` for 3 cycles mid-run and assert `start` mid-run. Required: the counters hold across the gap and the run is not restarted. Also, `in_valid` pulses in IDLE before `start` leave `vec_count`=0.
- Re-arm and reset: pulse `start` in DONE together with `in_valid`. Required: counters are 0 after the edge and `busy`=1. Then assert `rst_n`=0 asynchronously mid-run. Required: all outputs return to reset values without waiting for a clock edge.
- Saturation: `NUM_VECTORS`=200, `CNT_W`=4 is illegal, so use `CNT_W`=8, `NUM_VECTORS`=255 with every vector wrong. Required: `err_count`=255 with no wrap, `done`=1 after vector 255, `pass`=0.
